fifo_uart_tx: RTL



---
 rtl/fifo_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/fifo_uart_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: FSM encodings and frame sizing.
package fifo_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // One start bit plus one stop bit around the data word.
  localparam int FRAME_EXTRA_BITS = 2;

  function automatic int frame_bits(input int width);
    return width + FRAME_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: o_tick is high on the last clk cycle of every CLKS_PER_BIT period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A cleared counter never reports a period end, even when CLKS_PER_BIT is 1.
  assign o_tick = (r_cnt == LAST) && !i_clr;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a sample FIFO and sends 8N1-style frames, LSB first.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [2:0]       o_dbg_state
);

  localparam int BW = $clog2(WIDTH + 1);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit;
  logic             r_tx;
  logic             r_busy;
  logic             r_rd_en;

  logic             w_tick;
  logic             w_baud_clr;
  logic             w_pop_req;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_baud_clr  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_pop_req   = en && !fifo_empty;
  assign w_shift_nxt = r_shift >> 1;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_baud_clr),
    .o_tick(w_tick)
  );

  // The pop strobe is registered, so the request is taken on the edge that enters
  // IDLE (end of stop bit or idle wait) and the strobe is live during the IDLE cycle.
  // The FIFO data then arrives in the LOAD cycle, one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rd_en) begin
            r_rd_en <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end else if (w_pop_req) begin
            r_rd_en <= 1'b1;
          end
        end
        S_LOAD: begin
          r_shift <= fifo_rd_data;
          r_bit   <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_nxt;
            r_bit   <= r_bit + BW'(1);
            if (r_bit == BW'(WIDTH - 1)) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx <= w_shift_nxt[0];
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
            if (w_pop_req) begin
              r_rd_en <= 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en  = r_rd_en;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
